seg7_scan: RTL

Time-multiplexed driver for a multi-digit common-anode seven-segment display. It takes a packed hex word and per-digit decimal-point bits, then scans one digit at a time at a programmable refresh rate. All digit-enable and segment outputs are active-low. New data is double-buffered and committed only at a frame boundary, so a digit never shows a torn value mid-frame. The block sits at board top level, between the CPU's debug/display register and the display pins.

---
 rtl/seg7_scan.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode seven-segment driver with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     led_en,
  output logic                  led_ca,
  output logic                  led_cb,
  output logic                  led_cc,
  output logic                  led_cd,
  output logic                  led_ce,
  output logic                  led_cf,
  output logic                  led_cg,
  output logic                  led_dp,
  output logic                  frame
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [4*DIGITS-1:0]   pend_data, act_data, act_data_nxt;
  logic [DIGITS-1:0]     pend_dp, act_dp, act_dp_nxt;
  logic                  pend_valid;
  logic                  lit, lit_nxt;
  logic                  tick, wrap, commit;
  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  blank;
  logic [DIGITS-1:0]     en_c;
  logic [6:0]            glyph_c;
  logic [6:0]            seg_q;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0001100;
      4'ha: g = 7'b0001000;
      4'hb: g = 7'b1100000;
      4'hc: g = 7'b0110001;
      4'hd: g = 7'b1000010;
      4'he: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  always_comb begin
    tick         = (cnt == CNT_LAST);
    wrap         = tick && (idx == IDX_LAST);
    commit       = wrap && pend_valid;
    cnt_nxt      = tick ? '0 : cnt + 1'b1;
    idx_nxt      = idx;
    if (tick) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    act_data_nxt = commit ? pend_data : act_data;
    act_dp_nxt   = commit ? pend_dp : act_dp;
    lit_nxt      = lit | tick;
  end

  // Outputs are decoded from next-state index/data so select and segments move together.
  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    en_c   = '1;
    for (int j = 0; j < DIGITS; j++) begin
      if (idx_nxt == IW'(j)) begin
        nib     = act_data_nxt[4*j +: 4];
        dp_sel  = act_dp_nxt[j];
        en_c[j] = 1'b0;
      end
    end
    glyph_c = hex_glyph(nib);
  end

`ifdef SEG7_LZB_EN
  // Walk from the most significant digit down; a digit blanks only if it and all above are empty.
  always_comb begin
    logic tail_zero;
    tail_zero = 1'b1;
    blank     = 1'b0;
    for (int j = DIGITS - 1; j >= 1; j--) begin
      tail_zero = tail_zero && (act_data_nxt[4*j +: 4] == 4'h0) && !act_dp_nxt[j];
      if (idx_nxt == IW'(j)) blank = tail_zero;
    end
  end
`else
  always_comb begin
    blank = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      idx        <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      lit        <= 1'b0;
      led_en     <= '1;
      seg_q      <= '1;
      led_dp     <= 1'b1;
      frame      <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      act_data <= act_data_nxt;
      act_dp   <= act_dp_nxt;
      lit      <= lit_nxt;
      // A coincident load wins over the commit clearing valid.
      if (load) begin
        pend_data  <= data_in;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
      led_en <= lit_nxt ? en_c : '1;
      seg_q  <= (lit_nxt && !blank) ? glyph_c : '1;
      led_dp <= (lit_nxt && !blank) ? ~dp_sel : 1'b1;
      frame  <= wrap;
    end
  end

  assign led_ca = seg_q[6];
  assign led_cb = seg_q[5];
  assign led_cc = seg_q[4];
  assign led_cd = seg_q[3];
  assign led_ce = seg_q[2];
  assign led_cf = seg_q[1];
  assign led_cg = seg_q[0];

endmodule
